// File: rtl/mem_frame_arbiter.sv
// Frame-locked round-robin arbiter: N receive ports onto one memory write port; SOF grant costs one idle cycle, words then flow 1/cycle through one output register.
// Backpressure: i_mem_ready low holds the output word and deasserts o_ready of the granted port only; truncated frame tails are flushed.
module mem_frame_arbiter #(
    parameter int pPORT_WIDTH = 4,
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_WORDS  = 380
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [pPORT_WIDTH-1:0]             i_valid,
    output logic [pPORT_WIDTH-1:0]             o_ready,
    input  logic [pPORT_WIDTH*pDATA_WIDTH-1:0] i_data,
    input  logic [pPORT_WIDTH*2-1:0]           i_info,
    input  logic [pPORT_WIDTH*2-1:0]           i_extra_byte,
    output logic [pDATA_WIDTH-1:0]             o_data,
    output logic [$clog2(pPORT_WIDTH)-1:0]     o_port_num,
    output logic                               o_en_mem,
    input  logic                               i_mem_ready,
    output logic [1:0]                         o_info_port,
    output logic [1:0]                         o_extra_byte,
    output logic                               o_trunc,
    output logic                               o_protocol_err
);
    localparam int PW = $clog2(pPORT_WIDTH);
    localparam int CW = $clog2(pMAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          grant_q, grant_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic [pDATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]          port_q, port_d;
    logic [1:0]             info_q, info_d;
    logic [1:0]             xb_q, xb_d;
    logic                   trunc_q, trunc_d;
    logic                   perr_q, perr_d;

    logic [pDATA_WIDTH-1:0] data_p [pPORT_WIDTH];
    logic [1:0]             info_p [pPORT_WIDTH];
    logic [1:0]             xb_p   [pPORT_WIDTH];

    for (genvar p = 0; p < pPORT_WIDTH; p++) begin : g_unpack
        assign data_p[p] = i_data[p*pDATA_WIDTH +: pDATA_WIDTH];
        assign info_p[p] = i_info[p*2 +: 2];
        assign xb_p[p]   = i_extra_byte[p*2 +: 2];
    end

    logic [pPORT_WIDTH-1:0] rdy_c;
    logic                   lock_rdy;
    logic                   sof_hit;
    logic [PW-1:0]          sel;
    logic [PW-1:0]          cand;
    logic [PW-1:0]          next_g;
    logic [1:0]             acc_info;
    int                     idx;

    assign lock_rdy = !en_q || i_mem_ready;
    assign next_g   = (grant_q == PW'(pPORT_WIDTH - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        en_d     = en_q && !i_mem_ready;
        data_d   = data_q;
        port_d   = port_q;
        info_d   = info_q;
        xb_d     = xb_q;
        trunc_d  = 1'b0;
        perr_d   = 1'b0;
        rdy_c    = '0;
        sof_hit  = 1'b0;
        sel      = rptr_q;
        cand     = '0;
        acc_info = '0;
        idx      = 0;

        case (state_q)
            ST_IDLE: begin
                // First SOF found scanning from the round-robin pointer wins the frame.
                for (int i = 0; i < pPORT_WIDTH; i++) begin
                    idx = int'(rptr_q) + i;
                    if (idx >= pPORT_WIDTH) begin
                        idx = idx - pPORT_WIDTH;
                    end
                    cand = PW'(idx);
                    if (!sof_hit && i_valid[cand] && info_p[cand][0]) begin
                        sof_hit = 1'b1;
                        sel     = cand;
                    end
                end
                // Stray mid-frame words seen while idle are drained and reported.
                for (int p = 0; p < pPORT_WIDTH; p++) begin
                    if (i_valid[p] && !info_p[p][0]) begin
                        rdy_c[p] = 1'b1;
                        perr_d   = 1'b1;
                    end
                end
                if (sof_hit) begin
                    state_d = ST_LOCK;
                    grant_d = sel;
                    cnt_d   = '0;
                end
            end

            ST_LOCK: begin
                rdy_c[grant_q] = lock_rdy;
                if (i_valid[grant_q] && lock_rdy) begin
                    acc_info = info_p[grant_q];
                    if (cnt_q != '0 && acc_info[0]) begin
                        acc_info[0] = 1'b0;
                        perr_d      = 1'b1;
                    end
                    if (cnt_q != CW'(pMAX_WORDS)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (acc_info[1]) begin
                        state_d = ST_IDLE;
                        rptr_d  = next_g;
                    end else if (cnt_q == CW'(pMAX_WORDS - 1)) begin
                        // Frame hit the length cap: close it on this word, drop the rest.
                        acc_info[1] = 1'b1;
                        trunc_d     = 1'b1;
                        rptr_d      = next_g;
                        state_d     = ST_FLUSH;
                    end
                    en_d   = 1'b1;
                    data_d = data_p[grant_q];
                    port_d = grant_q;
                    info_d = acc_info;
                    xb_d   = xb_p[grant_q];
                end
            end

            ST_FLUSH: begin
                rdy_c[grant_q] = 1'b1;
                if (i_valid[grant_q] && info_p[grant_q][1]) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
            port_q  <= '0;
            info_q  <= '0;
            xb_q    <= '0;
            trunc_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            data_q  <= data_d;
            port_q  <= port_d;
            info_q  <= info_d;
            xb_q    <= xb_d;
            trunc_q <= trunc_d;
            perr_q  <= perr_d;
        end
    end

    // No word may be consumed from a port while the block is being reset.
    assign o_ready        = i_reset ? '0 : rdy_c;
    assign o_data         = data_q;
    assign o_port_num     = port_q;
    assign o_en_mem       = en_q;
    assign o_info_port    = info_q;
    assign o_extra_byte   = xb_q;
    assign o_trunc        = trunc_q;
    assign o_protocol_err = perr_q;

endmodule

// File: tb/tb_mem_frame_arbiter.sv
// Scoreboard bench for mem_frame_arbiter: directed frames push expected memory words, a negedge monitor pops and compares.
module tb_mem_frame_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   valid;
    logic [NP-1:0]   ready;
    logic [NP*DW-1:0] dat;
    logic [NP*2-1:0] inf;
    logic [NP*2-1:0] xb;
    logic [DW-1:0]   o_data;
    logic [1:0]      o_port_num;
    logic            o_en_mem;
    logic            mem_rdy;
    logic [1:0]      o_info_port;
    logic [1:0]      o_extra_byte;
    logic            o_trunc;
    logic            o_protocol_err;

    mem_frame_arbiter #(
        .pPORT_WIDTH(NP),
        .pDATA_WIDTH(DW),
        .pMAX_WORDS (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_data        (dat),
        .i_info        (inf),
        .i_extra_byte  (xb),
        .o_data        (o_data),
        .o_port_num    (o_port_num),
        .o_en_mem      (o_en_mem),
        .i_mem_ready   (mem_rdy),
        .o_info_port   (o_info_port),
        .o_extra_byte  (o_extra_byte),
        .o_trunc       (o_trunc),
        .o_protocol_err(o_protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          trunc_cnt = 0;
    int          perr_cnt = 0;
    int          cyc = 0;
    int          uniq = 0;
    logic        en_hist [4096];
    logic [37:0] expq [$];
    logic [37:0] mon_e;
    logic [35:0] sw [NP][16];
    int          sidx [NP];
    int          slen [NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every memory-accepted word is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && o_en_mem && mem_rdy) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected word: got data=%h port=%0d info=%b, required no output",
                         o_data, o_port_num, o_info_port);
            end else begin
                mon_e = expq.pop_front();
                check("sb word {data,port,info,xb}",
                      {26'b0, o_data, o_port_num, o_info_port, o_extra_byte}, {26'b0, mon_e});
            end
        end
        if (!rst && o_trunc) trunc_cnt++;
        if (!rst && o_protocol_err) perr_cnt++;
        if (cyc < 4096) en_hist[cyc] = o_en_mem;
        cyc++;
    end

    task automatic drive();
        logic [35:0] w;
        for (int p = 0; p < NP; p++) begin
            if (sidx[p] < slen[p]) begin
                w = sw[p][sidx[p]];
                valid[p] = 1'b1;
            end else begin
                w = '0;
                valid[p] = 1'b0;
            end
            dat[p*DW +: DW] = w[35:4];
            inf[p*2 +: 2]   = w[3:2];
            xb[p*2 +: 2]    = w[1:0];
        end
    endtask

    task automatic cycle();
        logic [NP-1:0] fire;
        @(negedge clk);
        fire = valid & ready;
        if (rst) fire = '0;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (fire[p]) sidx[p]++;
        drive();
    endtask

    task automatic clr_ports();
        for (int p = 0; p < NP; p++) begin
            sidx[p] = 0;
            slen[p] = 0;
        end
        drive();
    endtask

    task automatic add_word(input int p, input logic [1:0] wi, input logic [1:0] wx,
                            input bit push, input logic [1:0] ei);
        logic [31:0] d;
        uniq++;
        d = {4'(p), 12'h5A5, 16'(uniq)};
        sw[p][slen[p]] = {d, wi, wx};
        slen[p]++;
        if (push) expq.push_back({d, 2'(p), ei, wx});
    endtask

    function automatic bit busy();
        busy = 1'b0;
        for (int p = 0; p < NP; p++) if (sidx[p] < slen[p]) busy = 1'b1;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while ((expq.size() != 0 || busy()) && n < 60) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check({name, " queue drained"}, 64'(expq.size()), 64'd0);
    endtask

    int          s;
    int          t0, p0;
    logic [5:0]  ev;
    logic [31:0] d0;

    initial begin
        rst = 1'b1;
        mem_rdy = 1'b1;
        valid = '0;
        dat = '0;
        inf = '0;
        xb = '0;
        clr_ports();
        repeat (3) cycle();
        rst = 1'b0;
        #2;
        check("reset outputs",
              {23'b0, o_en_mem, o_data, o_port_num, o_info_port, o_extra_byte, ready, o_trunc, o_protocol_err},
              64'd0);

        // Port 0, 3-word frame: output starts 2 cycles after SOF, 3 consecutive words.
        clr_ports();
        add_word(0, 2'b01, 2'b00, 1, 2'b01);
        add_word(0, 2'b00, 2'b00, 1, 2'b00);
        add_word(0, 2'b10, 2'b10, 1, 2'b10);
        s = cyc;
        drive();
        drain("t1");
        for (int i = 0; i < 6; i++) ev[5-i] = en_hist[s+i];
        check("t1 o_en_mem timing from SOF cycle", 64'(ev), 64'b001110);

        // All four ports offer SOF together after reset: strict 0,1,2,3 order, no interleaving.
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        clr_ports();
        p0 = perr_cnt;
        for (int p = 0; p < NP; p++) begin
            add_word(p, 2'b01, 2'b00, 1, 2'b01);
            add_word(p, 2'b10, 2'b01, 1, 2'b10);
        end
        drive();
        drain("t2");
        // Pointer back at 0: port 0 must beat port 3.
        clr_ports();
        add_word(0, 2'b11, 2'b11, 1, 2'b11);
        add_word(3, 2'b11, 2'b10, 1, 2'b11);
        drive();
        drain("t2 rptr");
        check("t2 no protocol errors", 64'(perr_cnt - p0), 64'd0);

        // Memory stall for 4 cycles mid-frame; frame of exactly the cap with EOF is not truncated.
        clr_ports();
        t0 = trunc_cnt;
        add_word(1, 2'b01, 2'b00, 1, 2'b01);
        add_word(1, 2'b00, 2'b00, 1, 2'b00);
        add_word(1, 2'b00, 2'b00, 1, 2'b00);
        add_word(1, 2'b10, 2'b01, 1, 2'b10);
        d0 = sw[1][0][35:4];
        drive();
        cycle();
        cycle();
        mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t3 stalled o_data", 64'(o_data), 64'(d0));
            check("t3 stalled o_en_mem/o_ready", {62'b0, o_en_mem, ready[1]}, 64'b10);
            cycle();
        end
        mem_rdy = 1'b1;
        drain("t3");
        check("t3 no truncation at cap with EOF", 64'(trunc_cnt - t0), 64'd0);

        // Cap of 4 words: port 2 sends 6 words then EOF; word 4 closes the frame, 3 flushed.
        clr_ports();
        t0 = trunc_cnt;
        p0 = perr_cnt;
        add_word(2, 2'b01, 2'b00, 1, 2'b01);
        add_word(2, 2'b00, 2'b00, 1, 2'b00);
        add_word(2, 2'b00, 2'b00, 1, 2'b00);
        add_word(2, 2'b00, 2'b11, 1, 2'b10);
        add_word(2, 2'b00, 2'b00, 0, 2'b00);
        add_word(2, 2'b00, 2'b00, 0, 2'b00);
        add_word(2, 2'b10, 2'b01, 0, 2'b00);
        drive();
        drain("t4");
        check("t4 trunc pulses", 64'(trunc_cnt - t0), 64'd1);
        check("t4 flushed words consumed", 64'(sidx[2]), 64'd7);
        check("t4 no protocol errors", 64'(perr_cnt - p0), 64'd0);

        // Stray middle word while idle: dropped with one error pulse.
        clr_ports();
        p0 = perr_cnt;
        add_word(1, 2'b00, 2'b00, 0, 2'b00);
        drive();
        drain("t5");
        check("t5 protocol_err pulses", 64'(perr_cnt - p0), 64'd1);
        check("t5 stray word consumed", 64'(sidx[1]), 64'd1);

        // Second SOF inside a frame: SOF bit cleared, frame continues, one error pulse.
        clr_ports();
        p0 = perr_cnt;
        add_word(0, 2'b01, 2'b00, 1, 2'b01);
        add_word(0, 2'b01, 2'b00, 1, 2'b00);
        add_word(0, 2'b10, 2'b01, 1, 2'b10);
        drive();
        drain("t5b");
        check("t5b protocol_err pulses", 64'(perr_cnt - p0), 64'd1);

        // Reset during word 3 of a frame, then port 0 must win over port 3.
        clr_ports();
        add_word(2, 2'b01, 2'b00, 1, 2'b01);
        add_word(2, 2'b00, 2'b00, 0, 2'b00);
        add_word(2, 2'b00, 2'b00, 0, 2'b00);
        add_word(2, 2'b10, 2'b00, 0, 2'b00);
        drive();
        repeat (3) cycle();
        rst = 1'b1;
        clr_ports();
        cycle();
        rst = 1'b0;
        #2;
        check("t6 outputs after mid-frame reset",
              {23'b0, o_en_mem, o_data, o_port_num, o_info_port, o_extra_byte, ready, o_trunc, o_protocol_err},
              64'd0);
        check("t6 partial frame not emitted", 64'(expq.size()), 64'd0);
        add_word(0, 2'b11, 2'b01, 1, 2'b11);
        add_word(3, 2'b11, 2'b10, 1, 2'b11);
        drive();
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_frame_arbiter.md
# mem_frame_arbiter

Parametrised, frame-aware round-robin arbiter between the per-port receive paths and the shared frame-memory write port. It replaces fixed time-slot polling with valid/ready handshakes, backpressure from the memory and whole-frame grants. It locks onto one port from start-of-frame to end-of-frame, so memory never sees interleaved frames. It also enforces a maximum frame length and flushes truncated or malformed traffic.

## Interface
- pPORT_WIDTH, 4, number of input ports (2..16).
- pDATA_WIDTH, 32, data word width.
- pMAX_WORDS, 380, maximum words per frame before forced truncation (≥2).
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  pPORT_WIDTH  per-port word valid.
- o_ready  out  pPORT_WIDTH  per-port accept; a word transfers on a port when its i_valid and o_ready are both 1.
- i_data  in  pPORT_WIDTH*pDATA_WIDTH  port p at bits [p*pDATA_WIDTH +: pDATA_WIDTH].
- i_info  in  pPORT_WIDTH*2  per-port frame info: 2'b01 SOF, 2'b10 EOF, 2'b11 single-word frame, 2'b00 middle word.
- i_extra_byte  in  pPORT_WIDTH*2  per-port valid-byte code for the EOF word; passed through unchanged.
- o_data  out  pDATA_WIDTH  word to memory.
- o_port_num  out  $clog2(pPORT_WIDTH)  source port of o_data.
- o_en_mem  out  1  output word valid.
- i_mem_ready  in  1  memory accepts the word when o_en_mem and i_mem_ready are both 1.
- o_info_port  out  2  frame info of the output word; bit 1 is forced to 1 on truncation.
- o_extra_byte  out  2  valid-byte code of the output word.
- o_trunc  out  1  one-cycle pulse when a frame is truncated.
- o_protocol_err  out  1  one-cycle pulse when a malformed word is flushed or ignored.

## Operation
- Three-state FSM: IDLE, LOCK and FLUSH. It holds a grant register g and a round-robin pointer r_ptr.
- IDLE:
  - All o_ready are 0, except flushing as below.
  - Scan ports r_ptr, r_ptr+1, … (mod pPORT_WIDTH). The first port with i_valid=1 and i_info[0]=1 (SOF) becomes g.
  - Next state is LOCK and the word counter is cleared.
  - A port with i_valid=1 but no SOF, and not selected, gets o_ready=1 that cycle. Its word is discarded and o_protocol_err pulses.
- LOCK:
  - o_ready[g] = !o_en_mem || i_mem_ready. All other o_ready are 0.
  - Each accepted word loads the output register (data, g, info, extra_byte) and increments the word counter.
  - If an accepted word after the first has SOF set: the SOF bit is cleared on output, o_protocol_err pulses and the frame continues.
  - Accepted word with EOF (bit 1): next state IDLE, r_ptr = g+1 mod pPORT_WIDTH.
  - Accepted word that is number pMAX_WORDS without EOF: output info bit 1 is forced to 1 and extra_byte passes through. o_trunc pulses, r_ptr advances and the next state is FLUSH.
- FLUSH:
  - o_ready[g]=1 and the output register is not loaded.
  - Words are discarded until an accepted word carries EOF, then next state IDLE.
- Output register:
  - Holds its value while o_en_mem=1 and i_mem_ready=0.
  - o_en_mem clears after a memory accept unless a new word loads in the same cycle.
- Word counter width is $clog2(pMAX_WORDS+1). It saturates and never wraps.
- Single-word frame (2'b11) in LOCK: accepted, output, and the FSM returns to IDLE.

## Timing
- Reset values:
  - o_en_mem, o_data, o_port_num, o_info_port, o_extra_byte, o_ready, o_trunc and o_protocol_err are all 0.
  - State is IDLE, r_ptr=0, counter=0.
- Reset mid-frame aborts immediately. Outputs are zero on the next edge and there is no EOF generation. The memory side discards the partial frame.
- Grant latency: SOF seen in IDLE in cycle n; o_ready[g]=1 in cycle n+1. There is one bubble per frame.
- Data latency: a word accepted at edge k appears on o_en_mem/o_data after edge k. Throughput is 1 word/cycle while i_mem_ready=1.
- Back-to-back frames from the same port cost one IDLE cycle between EOF and the next SOF grant.
- A port that deasserts i_valid mid-frame keeps the grant indefinitely. Frames are never interleaved.
- o_trunc and o_protocol_err are registered and high for exactly one cycle per event.

## Test plan
- Reset, then port 0 sends 3 words (01,00,10) with i_mem_ready=1 -> o_en_mem high for 3 consecutive cycles starting 2 cycles after SOF, o_port_num=0, info 01,00,10.
- Ports 0–3 all present SOF simultaneously, 2-word frames -> grants in order 0,1,2,3. Output shows no interleaving and r_ptr=0 at the end.
- i_mem_ready=0 for 4 cycles mid-frame -> o_data stable, o_ready[g]=0, no word lost or duplicated.
- pMAX_WORDS=4, port 2 sends 6 words then EOF -> 4 words output, 4th with info bit1=1. o_trunc pulses once; remaining 3 words flushed with o_en_mem=0.
- Port 1 valid with info 00 in IDLE -> word dropped, o_protocol_err pulses once, no output.
- Reset asserted during word 3 of a frame -> all outputs 0 next cycle; new SOF afterwards granted starting from port 0.
